// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-output bundle for seq_pattern_tx.
// The master side requests transmissions. The slave side is the transmitter.
interface seq_pattern_tx_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, repeat_cnt,
        input  out, out_valid, busy, done
    );

    modport slave (
        input  start, abort, pattern, repeat_cnt,
        output out, out_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched WIDTH-bit pattern MSB first, repeat_cnt+1 times,
// with optional GAP idle cycles between repetitions and a one-cycle done pulse at the end.
module seq_pattern_tx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 0
) (
    input  logic            clk,
    input  logic            rst,
    seq_pattern_tx_if.slave bus
);
    localparam int BIT_W    = $clog2(WIDTH);
    localparam int GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_nxt;
    logic [CNT_W-1:0] rep_cnt, rep_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [WIDTH-1:0] pat_reg, pat_nxt;
    logic             out_d, valid_d, busy_d, done_d;
    logic             out_q, valid_q, busy_q, done_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            pat_reg <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_nxt;
            rep_cnt <= rep_nxt;
            gap_cnt <= gap_nxt;
            pat_reg <= pat_nxt;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        rep_nxt   = rep_cnt;
        gap_nxt   = gap_cnt;
        pat_nxt   = pat_reg;
        case (state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt = S_SHIFT;
                    pat_nxt   = bus.pattern;
                    rep_nxt   = bus.repeat_cnt;
                    bit_nxt   = BIT_W'(WIDTH - 1);
                end
            end
            S_SHIFT: begin
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else if (bit_cnt != '0) begin
                    bit_nxt = bit_cnt - BIT_W'(1);
                end else if (rep_cnt == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    rep_nxt = rep_cnt - CNT_W'(1);
                    bit_nxt = BIT_W'(WIDTH - 1);
                    if (GAP == 0) begin
                        state_nxt = S_SHIFT;
                    end else begin
                        state_nxt = S_GAP;
                        gap_nxt   = '0;
                    end
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else if (gap_cnt == GAP_W'(GAP_LAST)) begin
                    state_nxt = S_SHIFT;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and then registered, so the
    // first bit appears right after the edge that accepts start.
    always_comb begin
        out_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_nxt)
            S_SHIFT: begin
                out_d   = pat_nxt[bit_nxt];
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_GAP:   busy_d = 1'b1;
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one instance with GAP=0 and one with GAP=2.
// Observed vectors are packed {out, out_valid, busy, done}.
module tb_seq_pattern_tx;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_pattern_tx_if #(.WIDTH(4), .CNT_W(4)) if0 ();
    seq_pattern_tx_if #(.WIDTH(4), .CNT_W(4)) if2 ();

    seq_pattern_tx #(.WIDTH(4), .CNT_W(4), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    seq_pattern_tx #(.WIDTH(4), .CNT_W(4), .GAP(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    logic [3:0] obs0, obs2;
    assign obs0 = {if0.out, if0.out_valid, if0.busy, if0.done};
    assign obs2 = {if2.out, if2.out_valid, if2.busy, if2.done};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        if0.start      = 1'b1;
        if0.abort      = 1'b0;
        if0.pattern    = 4'b1111;
        if0.repeat_cnt = 4'd0;
        if2.start      = 1'b0;
        if2.abort      = 1'b0;
        if2.pattern    = 4'b0000;
        if2.repeat_cnt = 4'd0;
        tick();
        tick();
        total++;
        if (obs0 !== 4'b0000) begin
            bad++;
            $display("FAIL reset_dut0: got %b expected %b", obs0, 4'b0000);
        end
        total++;
        if (obs2 !== 4'b0000) begin
            bad++;
            $display("FAIL reset_dut2: got %b expected %b", obs2, 4'b0000);
        end
        if0.start = 1'b0;
        rst       = 1'b0;
        tick();
        total++;
        if (obs0 !== 4'b0000) begin
            bad++;
            $display("FAIL reset_idle: got %b expected %b", obs0, 4'b0000);
        end
    endtask

    task automatic test_single();
        logic [23:0] seq = {4'b1110, 4'b0110, 4'b0110, 4'b1110, 4'b0001, 4'b0000};
        if0.pattern    = 4'b1001;
        if0.repeat_cnt = 4'd0;
        if0.start      = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if0.start = 1'b0;
            total++;
            if (obs0 !== seq[4*(5-i) +: 4]) begin
                bad++;
                $display("FAIL single[%0d]: got %b expected %b", i, obs0, seq[4*(5-i) +: 4]);
            end
        end
    endtask

    task automatic test_repeat();
        logic [11:0] bits = 12'b1001_1001_1001;
        if0.pattern    = 4'b1001;
        if0.repeat_cnt = 4'd2;
        if0.start      = 1'b1;
        for (int i = 11; i >= 0; i--) begin
            tick();
            if0.start      = 1'b0;
            if0.pattern    = 4'b0110;
            if0.repeat_cnt = 4'd0;
            total++;
            if (obs0 !== {bits[i], 3'b110}) begin
                bad++;
                $display("FAIL repeat_bit[%0d]: got %b expected %b", 11 - i, obs0, {bits[i], 3'b110});
            end
        end
        tick();
        total++;
        if (obs0 !== 4'b0001) begin
            bad++;
            $display("FAIL repeat_done: got %b expected %b", obs0, 4'b0001);
        end
        tick();
        total++;
        if (obs0 !== 4'b0000) begin
            bad++;
            $display("FAIL repeat_idle: got %b expected %b", obs0, 4'b0000);
        end
    endtask

    task automatic test_gap();
        logic [47:0] seq = {4'b1110, 4'b1110, 4'b0110, 4'b0110, 4'b0010, 4'b0010,
                            4'b1110, 4'b1110, 4'b0110, 4'b0110, 4'b0001, 4'b0000};
        if2.pattern    = 4'b1100;
        if2.repeat_cnt = 4'd1;
        if2.start      = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if2.start = 1'b0;
            total++;
            if (obs2 !== seq[4*(11-i) +: 4]) begin
                bad++;
                $display("FAIL gap[%0d]: got %b expected %b", i, obs2, seq[4*(11-i) +: 4]);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] seq = {4'b1110, 4'b0110, 4'b0110, 4'b0000,
                            4'b1110, 4'b0110, 4'b0110, 4'b1110};
        if0.pattern    = 4'b1001;
        if0.repeat_cnt = 4'd0;
        if0.start      = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if0.start = (i == 3);
            if0.abort = (i == 2);
            total++;
            if (obs0 !== seq[4*(7-i) +: 4]) begin
                bad++;
                $display("FAIL abort[%0d]: got %b expected %b", i, obs0, seq[4*(7-i) +: 4]);
            end
        end
        tick();
        total++;
        if (obs0 !== 4'b0001) begin
            bad++;
            $display("FAIL abort_restart_done: got %b expected %b", obs0, 4'b0001);
        end
        tick();
        if0.start = 1'b1;
        if0.abort = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if0.start = 1'b0;
            if0.abort = 1'b0;
            total++;
            if (obs0 !== 4'b0000) begin
                bad++;
                $display("FAIL start_abort_idle[%0d]: got %b expected %b", i, obs0, 4'b0000);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] seq = {4'b1110, 4'b0110, 4'b0000, 4'b1110,
                            4'b0110, 4'b0110, 4'b1110, 4'b0001};
        if0.pattern    = 4'b1001;
        if0.repeat_cnt = 4'd0;
        if0.start      = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            rst       = (i == 1);
            if0.start = (i <= 2);
            total++;
            if (obs0 !== seq[4*(7-i) +: 4]) begin
                bad++;
                $display("FAIL reset_mid[%0d]: got %b expected %b", i, obs0, seq[4*(7-i) +: 4]);
            end
        end
    endtask

    task automatic test_hold_start();
        logic [43:0] seq = {4'b1110, 4'b0110, 4'b0110, 4'b1110, 4'b0001, 4'b0000,
                            4'b0110, 4'b1110, 4'b1110, 4'b0110, 4'b0001};
        tick();
        if0.pattern    = 4'b1001;
        if0.repeat_cnt = 4'd0;
        if0.start      = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            if0.pattern = 4'b0110;
            if (i == 9) if0.start = 1'b0;
            total++;
            if (obs0 !== seq[4*(10-i) +: 4]) begin
                bad++;
                $display("FAIL hold_start[%0d]: got %b expected %b", i, obs0, seq[4*(10-i) +: 4]);
            end
        end
        if0.start = 1'b0;
        tick();
    endtask

    task automatic test_allones();
        int n_valid = 0;
        int n_ones  = 0;
        int n_cyc   = 0;
        bit seen    = 1'b0;
        if0.pattern    = 4'b1000;
        if0.repeat_cnt = 4'hF;
        if0.start      = 1'b1;
        while (!seen && n_cyc < 200) begin
            tick();
            if0.start = 1'b0;
            n_cyc++;
            if (obs0[2]) n_valid++;
            if (obs0[3]) n_ones++;
            if (obs0[0]) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL allones_done: got no done pulse within %0d cycles, expected one", n_cyc);
        end
        total++;
        if (n_valid != 64) begin
            bad++;
            $display("FAIL allones_valid: got %0d expected %0d", n_valid, 64);
        end
        total++;
        if (n_ones != 16) begin
            bad++;
            $display("FAIL allones_ones: got %0d expected %0d", n_ones, 16);
        end
        tick();
        total++;
        if (obs0 !== 4'b0000) begin
            bad++;
            $display("FAIL allones_idle: got %b expected %b", obs0, 4'b0000);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_gap();
        test_abort();
        test_reset_mid();
        test_hold_start();
        test_allones();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
